// File: rtl/tag_nios_system_leds_out_if.sv
// Avalon-MM slave bus bundle for the LED output port.
// The CPU side drives select/strobe/address/data; the port returns registered read data.
interface tag_nios_system_leds_out_if;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write_n,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/tag_nios_system_leds_out.sv
// LED output port: data register with atomic set/clear, per-bit blink mask gated by a
// free-running blink phase, and a one-cycle registered read path.
module tag_nios_system_leds_out #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned RESET_VALUE  = 0,
    parameter int unsigned PERIOD_WIDTH = 26,
    parameter int unsigned RESET_PERIOD = 25000000
) (
    input  logic                          clk,
    input  logic                          reset,
    tag_nios_system_leds_out_if.slave     bus,
    output logic [DATA_WIDTH-1:0]         out_port
);

    typedef enum logic [2:0] {
        AddrData   = 3'd0,
        AddrBlink  = 3'd1,
        AddrPeriod = 3'd2,
        AddrStatus = 3'd3,
        AddrOutSet = 3'd4,
        AddrOutClr = 3'd5,
        AddrRsvd6  = 3'd6,
        AddrRsvd7  = 3'd7
    } reg_addr_e;

    reg_addr_e               addr;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [PERIOD_WIDTH-1:0] wr_period;
    logic                    unused_wdata;

    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   blink_q, blink_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [31:0]             readdata_q, readdata_d;

    assign addr      = reg_addr_e'(bus.address);
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wr_data   = bus.writedata[DATA_WIDTH-1:0];
    assign wr_period = bus.writedata[PERIOD_WIDTH-1:0];
    // Upper write-data bits are architecturally ignored.
    assign unused_wdata = ^bus.writedata;

    // Data and blink-mask registers, including single-cycle set/clear read-modify-write.
    always_comb begin
        data_d  = data_q;
        blink_d = blink_q;
        if (wr_en) begin
            case (addr)
                AddrData:   data_d  = wr_data;
                AddrBlink:  blink_d = wr_data;
                AddrOutSet: data_d  = data_q | wr_data;
                AddrOutClr: data_d  = data_q & ~wr_data;
                default:    ;
            endcase
        end
    end

    // Blink engine: a PERIOD write wins over an expiry in the same cycle.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr_en && addr == AddrPeriod) begin
            period_d = wr_period;
            cnt_d    = wr_period;
            phase_d  = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
    end

    // Read mux samples pre-update register contents, so same-cycle reads return old values.
    always_comb begin
        readdata_d = '0;
        case (addr)
            AddrData:   readdata_d = 32'(data_q);
            AddrBlink:  readdata_d = 32'(blink_q);
            AddrPeriod: readdata_d = 32'(period_q);
            AddrStatus: readdata_d[0] = phase_q;
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= DATA_WIDTH'(RESET_VALUE);
            blink_q    <= '0;
            period_q   <= PERIOD_WIDTH'(RESET_PERIOD);
            cnt_q      <= PERIOD_WIDTH'(RESET_PERIOD);
            phase_q    <= 1'b1;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            blink_q    <= blink_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = data_q & ~(blink_q & {DATA_WIDTH{~phase_q}});

endmodule

// File: tb/tb_tag_nios_system_leds_out.sv
// Randomized and directed bench for the LED output port against a time-based reference model.
// The model derives the blink phase from elapsed cycles since the last period (re)start.
module tb_tag_nios_system_leds_out;

    localparam int unsigned DW        = 10;
    localparam int unsigned PW        = 26;
    localparam int unsigned RstValue  = 32'h155;
    localparam int unsigned RstPeriod = 25000000;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] out_port;

    tag_nios_system_leds_out_if bus ();

    tag_nios_system_leds_out #(
        .DATA_WIDTH   (DW),
        .RESET_VALUE  (RstValue),
        .PERIOD_WIDTH (PW),
        .RESET_PERIOD (RstPeriod)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state.
    logic [DW-1:0]   m_data;
    logic [DW-1:0]   m_blink;
    logic [PW-1:0]   m_period;
    longint unsigned m_k;   // edges since the period last (re)started
    logic [31:0]     m_rd;

    function automatic logic m_phase();
        if (m_period == '0) return 1'b1;
        return ((m_k / (64'(m_period) + 64'd1)) % 64'd2) == 64'd0;
    endfunction

    function automatic logic [DW-1:0] m_out();
        return m_data & ~(m_blink & {DW{~m_phase()}});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, let the edge happen, advance the model, then compare.
    task automatic cycle(input logic cs, input logic wn, input logic [2:0] addr,
                         input logic [31:0] wd);
        logic [31:0] exp_rd;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = addr;
        bus.writedata  = wd;
        @(posedge clk);
        case (addr)
            3'd0:    exp_rd = 32'(m_data);
            3'd1:    exp_rd = 32'(m_blink);
            3'd2:    exp_rd = 32'(m_period);
            3'd3:    exp_rd = {31'b0, m_phase()};
            default: exp_rd = 32'b0;
        endcase
        if (cs && !wn) begin
            case (addr)
                3'd0: m_data = wd[DW-1:0];
                3'd1: m_blink = wd[DW-1:0];
                3'd2: m_period = wd[PW-1:0];
                3'd4: m_data = m_data | wd[DW-1:0];
                3'd5: m_data = m_data & ~wd[DW-1:0];
                default: ;
            endcase
        end
        if (cs && !wn && addr == 3'd2) m_k = 0;
        else m_k++;
        m_rd = exp_rd;
        @(negedge clk);
        check("out_port", 32'(out_port), 32'(m_out()));
        check("readdata", bus.readdata, m_rd);
    endtask

    // Two-cycle reset with a write attempted underneath it.
    task automatic do_reset(input logic [31:0] wd);
        reset          = 1'b1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 3'd0;
        bus.writedata  = wd;
        repeat (2) @(posedge clk);
        m_data   = DW'(RstValue);
        m_blink  = '0;
        m_period = PW'(RstPeriod);
        m_k      = 0;
        m_rd     = 32'b0;
        @(negedge clk);
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check("rst_out", 32'(out_port), 32'(m_out()));
        check("rst_rd", bus.readdata, m_rd);
    endtask

    initial begin
        logic [31:0] wd;
        logic [2:0]  a;
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'b0;

        // Reset
        do_reset(32'h3ff);
        check("rst_out_val", 32'(out_port), 32'h155);
        cycle(1'b0, 1'b1, 3'd2, 32'h0);
        check("rst_period", bus.readdata, 32'd25000000);

        // Set / clear on consecutive cycles
        cycle(1'b1, 1'b0, 3'd0, 32'hffff_f0f0);
        check("set_clr_0", 32'(out_port), 32'h0f0);
        cycle(1'b1, 1'b0, 3'd4, 32'h003);
        check("set_clr_1", 32'(out_port), 32'h0f3);
        cycle(1'b1, 1'b0, 3'd5, 32'h030);
        check("set_clr_2", 32'(out_port), 32'h0c3);
        cycle(1'b0, 1'b1, 3'd0, 32'h0);
        check("set_clr_rd", bus.readdata, 32'h0c3);

        // Blink bit 0 with period 3
        cycle(1'b1, 1'b0, 3'd0, 32'h3ff);
        cycle(1'b1, 1'b0, 3'd1, 32'h001);
        cycle(1'b1, 1'b0, 3'd2, 32'h003);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 1'b1, 3'd3, 32'h0);
            check("blink_b0", 32'(out_port[0]), 32'(((i / 4) % 2) == 0));
            check("blink_hi", 32'(out_port[DW-1:1]), 32'h1ff);
        end

        // Zero period holds blinked bits solid
        cycle(1'b1, 1'b0, 3'd1, 32'h3ff);
        cycle(1'b1, 1'b0, 3'd2, 32'h0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, 3'd3, 32'h0);
            check("zero_per_out", 32'(out_port), 32'h3ff);
            check("zero_per_st", bus.readdata, 32'h1);
        end

        // Collision: PERIOD write on the expiry edge
        cycle(1'b1, 1'b0, 3'd2, 32'h3);
        repeat (3) cycle(1'b0, 1'b1, 3'd3, 32'h0);
        cycle(1'b1, 1'b0, 3'd2, 32'h5);
        check("coll_phase", 32'(out_port), 32'h3ff);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 3'd3, 32'h0);
            check("coll_next", 32'(out_port), (i < 6) ? 32'h3ff : 32'h000);
        end

        // Gating and reserved addresses
        cycle(1'b1, 1'b0, 3'd1, 32'h0);
        cycle(1'b1, 1'b0, 3'd0, 32'h2a5);
        cycle(1'b0, 1'b0, 3'd0, 32'h000);
        cycle(1'b1, 1'b0, 3'd6, 32'hffff_ffff);
        cycle(1'b1, 1'b0, 3'd3, 32'hffff_ffff);
        check("gate_out", 32'(out_port), 32'h2a5);
        for (int i = 4; i < 8; i++) begin
            cycle(1'b0, 1'b1, 3'(i), 32'h0);
            check("rsvd_rd", bus.readdata, 32'h0);
        end

        // Randomized traffic with occasional mid-blink resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom);
            end else begin
                a  = 3'($urandom_range(0, 7));
                wd = $urandom;
                if (a == 3'd2) wd = (wd & 32'hfc00_0000) | 32'($urandom_range(0, 6));
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) >= 4, a, wd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_nios_system_leds_out.md
# tag_nios_system_leds_out

Avalon-MM slave output port driving the board LEDs from the Nios II, the write-side counterpart of the button input port. Software writes a data register directly, or sets and clears individual bits atomically. A per-bit blink mask gates selected bits with a programmable free-running blink phase, so LEDs can flash without CPU involvement. The block sits on the system interconnect next to the button port and uses the same registered read path, with a one-cycle read latency.

## Interface
- `DATA_WIDTH`, 10: number of output bits.
- `RESET_VALUE`, 0: data register value after reset.
- `PERIOD_WIDTH`, 26: width of the blink period register and counter (≤ 32).
- `RESET_PERIOD`, 25000000: blink period register value after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `chipselect`  in  1  slave select; a write is accepted only when this is high.
- `write_n`  in  1  active-low write strobe.
- `address`  in  3  word register index.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  DATA_WIDTH  LED drive.

## Operation
- A write is accepted in a cycle when `chipselect`=1 and `write_n`=0. At most one write is accepted per cycle.
- Register map (only the low DATA_WIDTH or PERIOD_WIDTH bits of `writedata` are used; the upper bits are ignored):
  - 0 DATA (rw): `data <= writedata`.
  - 1 BLINK (rw): `blink_en <= writedata`.
  - 2 PERIOD (rw): `period <= writedata`. The same write also sets `cnt <= writedata` and `phase <= 1`.
  - 3 STATUS (ro): bit 0 = `phase`; the other bits read 0. Writes are ignored.
  - 4 OUTSET (wo): `data <= data | writedata`.
  - 5 OUTCLEAR (wo): `data <= data & ~writedata`.
  - 6, 7: reserved. Reads return 0; writes are ignored.
  - OUTSET and OUTCLEAR read as 0.
- Blink engine (free-running; it never stalls):
  - If `period` = 0: `phase` is held at 1 and `cnt` is held at 0, so blink-enabled bits are solid.
  - Else, when `cnt` = 0: `cnt <= period` and `phase <= ~phase`.
  - Else: `cnt <= cnt - 1`.
  - Each phase therefore lasts `period`+1 cycles.
  - A write to PERIOD in the same cycle as an expiry takes priority: the counter is reloaded with the written value and `phase` is forced to 1. No toggle occurs that cycle.
- Output: `out_port = data & ~(blink_en & {DATA_WIDTH{~phase}})`.
  - Bits not in the blink mask follow `data`.
  - Blinked bits show `data` while `phase`=1 and show 0 while `phase`=0.
  - `out_port` is combinational from registers only; it has no path from bus inputs.
- Read path: every cycle, `readdata <= {zero-extended register selected by address}`, regardless of `chipselect`.
- Reset (synchronous, `reset`=1 at a clock edge):
  - `data = RESET_VALUE`, `blink_en = 0`, `period = RESET_PERIOD`, `cnt = RESET_PERIOD`, `phase = 1`, `readdata = 0`.
  - Resulting `out_port = RESET_VALUE`.
  - Reset overrides any simultaneous write.
  - Asserting reset in the middle of a blink cycle restarts the engine from the reset values.

## Timing
- Write at edge N: the register updates at edge N; `out_port` shows the new value in cycle N+1, i.e. after edge N.
- Read latency is 1 cycle: `readdata` after edge N reflects `address` and the register contents sampled at edge N.
  - A read of DATA in the cycle immediately after a write to DATA returns the new value.
  - A read presented in the same cycle as the write returns the old value.
- Blink toggle: with `period` = P written at edge N, `phase` goes to 0 at edge N+P+1 and back to 1 at edge N+2P+2.
- OUTSET and OUTCLEAR are single-cycle read-modify-write operations. Back-to-back writes on consecutive cycles each take effect without loss.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `RESET_VALUE`=0x155 -> `out_port`=0x155, `readdata`=0, and a read of address 2 returns 25000000.
- **Set/clear:** write DATA=0x0F0, then OUTSET=0x003, then OUTCLEAR=0x030 on consecutive cycles -> `out_port` steps 0x0F0, 0x0F3, 0x0C3; a read of address 0 returns 0x0C3.
- **Blink:** write DATA=0x3FF, BLINK=0x001, PERIOD=3 -> bit 0 alternates 4 cycles high, 4 cycles low; bits 9:1 stay high; STATUS bit 0 matches bit 0.
- **Zero period:** write PERIOD=0 with BLINK=0x3FF -> `out_port`=`data` constantly and STATUS=1 for 100 cycles.
- **Collision:** write PERIOD=5 on the exact cycle `cnt` reaches 0 -> no toggle that cycle, `phase`=1, and the next toggle comes 6 cycles later.
- **Gating and reserved addresses:** write with `chipselect`=0, write to address 6, and write to STATUS -> no register changes; reads of addresses 4-7 return 0.
